// File: rtl/alu_exec_unit.sv
// Registered ALU execute stage: single-cycle logic/arith ops plus an iterative
// 1-bit/cycle shifter, valid/ready on both sides. Optional ALU_OVF_EN adds an overflow flag.
module alu_exec_unit #(
  parameter int XLEN = 32,
  localparam int SHW = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_ctrl,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
`ifdef ALU_OVF_EN
  output logic            overflow,
`endif
  output logic            zero
);

  localparam logic [3:0] OP_AND = 4'b0000, OP_OR  = 4'b0001, OP_ADD = 4'b0010,
                         OP_SUB = 4'b0110, OP_SLT = 4'b0111, OP_NOR = 4'b1100,
                         OP_SLL = 4'b1000, OP_SRL = 4'b1001, OP_SRA = 4'b1010;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            zero_q, zero_d;
  logic [SHW-1:0]  cnt_q, cnt_d;
  logic [1:0]      sh_op_q, sh_op_d;

  logic            accept, is_shift, ld_imm, shift_fin;
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] alu_r, shift_one;

  assign in_ready  = (state_q == IDLE) || (state_q == DONE && out_ready);
  assign accept    = in_valid && in_ready;
  assign shamt     = op_b[SHW-1:0];
  assign is_shift  = (alu_ctrl == OP_SLL) || (alu_ctrl == OP_SRL) || (alu_ctrl == OP_SRA);
  // Ops that complete straight from the accept edge (incl. shift by zero).
  assign ld_imm    = accept && !(is_shift && shamt != '0);
  assign shift_fin = (state_q == SHIFT) && (cnt_q == SHW'(1));

  always_comb begin
    alu_r = '0;
    case (alu_ctrl)
      OP_AND: alu_r = op_a & op_b;
      OP_OR:  alu_r = op_a | op_b;
      OP_ADD: alu_r = op_a + op_b;
      OP_SUB: alu_r = op_a - op_b;
      OP_SLT: alu_r = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      OP_NOR: alu_r = ~(op_a | op_b);
      OP_SLL, OP_SRL, OP_SRA: alu_r = op_a;
      default: alu_r = '0;
    endcase
  end

  // sh_op_q holds alu_ctrl[1:0] of the captured shift: 00 SLL, 01 SRL, 10 SRA.
  always_comb begin
    case (sh_op_q)
      2'b00:   shift_one = {result_q[XLEN-2:0], 1'b0};
      2'b01:   shift_one = {1'b0, result_q[XLEN-1:1]};
      default: shift_one = {result_q[XLEN-1], result_q[XLEN-1:1]};
    endcase
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    zero_d   = zero_q;
    cnt_d    = cnt_q;
    sh_op_d  = sh_op_q;
    case (state_q)
      SHIFT: begin
        result_d = shift_one;
        cnt_d    = cnt_q - SHW'(1);
        if (shift_fin) begin
          state_d = DONE;
          zero_d  = (shift_one == '0);
        end
      end
      default: begin
        if (state_q == DONE && out_ready) state_d = IDLE;
        if (ld_imm) begin
          state_d  = DONE;
          result_d = alu_r;
          zero_d   = (alu_r == '0);
        end else if (accept) begin
          // Shift register lives in result_q; out_valid stays low until it settles.
          state_d  = SHIFT;
          result_d = op_a;
          cnt_d    = shamt;
          sh_op_d  = alu_ctrl[1:0];
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      result_q <= '0;
      zero_q   <= 1'b0;
      cnt_q    <= '0;
      sh_op_q  <= 2'b00;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      cnt_q    <= cnt_d;
      sh_op_q  <= sh_op_d;
    end
  end

  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign zero      = zero_q;

`ifdef ALU_OVF_EN
  logic ovf_q, ovf_d, bp_msb, ovf_calc;

  assign bp_msb   = (alu_ctrl == OP_SUB) ? ~op_b[XLEN-1] : op_b[XLEN-1];
  assign ovf_calc = ((alu_ctrl == OP_ADD) || (alu_ctrl == OP_SUB)) &&
                    (op_a[XLEN-1] == bp_msb) && (alu_r[XLEN-1] != op_a[XLEN-1]);

  always_comb begin
    ovf_d = ovf_q;
    if (ld_imm)         ovf_d = ovf_calc;
    else if (shift_fin) ovf_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end

  assign overflow = ovf_q;
`endif

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: directed cases then random ops against a
// plain-arithmetic reference model; a monitor checks every presented result.
module tb_alu_exec_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  alu_ctrl = '0;
  logic [31:0] op_a = '0, op_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic        zero;
`ifdef ALU_OVF_EN
  logic        ovf;
`endif

  alu_exec_unit #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_ctrl(alu_ctrl), .op_a(op_a), .op_b(op_b), .out_valid(out_valid),
    .out_ready(out_ready), .result(result),
`ifdef ALU_OVF_EN
    .overflow(ovf),
`endif
    .zero(zero));

  always #5 clk = ~clk;

  typedef struct { logic [31:0] r; logic z; logic v; int acc; int lat; } exp_t;
  exp_t sb[$];
  int   total = 0, bad = 0, cyc = 0, rdy_mode = 0;
  bit   head_seen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom_range(0, 3) != 0);
      default: out_ready = 1'b0;
    endcase
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model from the opcode table, using native signed arithmetic.
  function automatic exp_t model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    exp_t   e;
    longint s;
    int     n;
    n = int'(b & 32'd31);
    e.v = 1'b0; e.lat = 1; e.acc = 0;
    case (c)
      4'b0000: e.r = a & b;
      4'b0001: e.r = a | b;
      4'b0010: begin
        s = longint'($signed(a)) + longint'($signed(b));
        e.r = a + b;
        e.v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'b0110: begin
        s = longint'($signed(a)) - longint'($signed(b));
        e.r = a - b;
        e.v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'b0111: e.r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1100: e.r = ~(a | b);
      4'b1000: begin e.r = a << n;                   e.lat = n + 1; end
      4'b1001: begin e.r = a >> n;                   e.lat = n + 1; end
      4'b1010: begin e.r = 32'($signed(a) >>> n);    e.lat = n + 1; end
      default: e.r = 32'd0;
    endcase
    e.z = (e.r == 32'd0);
    return e;
  endfunction

  // Monitor: check the head while out_valid, pop on handshake, then record any accept.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      sb.delete();
      head_seen = 0;
    end else begin
      if (out_valid) begin
        if (sb.size() == 0) begin
          chk("spurious_out_valid", 1, 0);
        end else begin
          e = sb[0];
          chk("result", result, e.r);
          chk("zero", zero, e.z);
`ifdef ALU_OVF_EN
          chk("overflow", ovf, e.v);
`endif
          if (!head_seen) begin
            chk("latency", cyc - e.acc, e.lat);
            head_seen = 1;
          end
          chk("in_ready_done", in_ready, out_ready);
          if (out_ready) begin
            void'(sb.pop_front());
            head_seen = 0;
          end
        end
      end else if (sb.size() != 0) begin
        chk("in_ready_busy", in_ready, 0);
      end
      if (in_valid && in_ready) begin
        e = model(alu_ctrl, op_a, op_b);
        e.acc = cyc;
        sb.push_back(e);
      end
    end
  end

  // Drive a request and hold it until accepted; scramble inputs afterwards.
  task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    bit done = 0;
    in_valid = 1'b1; alu_ctrl = c; op_a = a; op_b = b;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      done = in_ready;
      @(posedge clk); #1;
    end
    if (!done) chk("accept_timeout", 0, 1);
    in_valid = 1'b0; alu_ctrl = 4'($urandom); op_a = $urandom; op_b = $urandom;
  endtask

  task automatic drain();
    bit done = 0;
    for (int k = 0; k < 300 && !done; k++) begin
      @(posedge clk); #2;
      done = (sb.size() == 0) && !out_valid;
    end
    if (!done) chk("drain_timeout", 0, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] codes [9];
    logic [3:0] c;
    logic [31:0] a, b;
    codes = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b1000, 4'b1001, 4'b1010};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_zero", zero, 0);
`ifdef ALU_OVF_EN
    chk("rst_overflow", ovf, 0);
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;

    issue(4'b0010, 32'h7FFF_FFFF, 32'd1);
    issue(4'b0110, 32'd5, 32'd5);
    issue(4'b1010, 32'h8000_0000, 32'd4);
    issue(4'b1000, 32'h1234_5678, 32'd0);
    issue(4'b0000, 32'hF0F0_1234, 32'h0FF0_FFFF);
    issue(4'b0001, 32'hF000_0000, 32'h0000_000F);
    issue(4'b0111, 32'hFFFF_FFFF, 32'd1);
    issue(4'b0011, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    drain();

    rdy_mode = 2;
    issue(4'b1100, 32'h0000_FFFF, 32'h00FF_0000);
    repeat (4) @(posedge clk);
    rdy_mode = 0;
    drain();

    issue(4'b1000, 32'h0000_0001, 32'd10);
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("post_rst_in_ready", in_ready, 1);
    repeat (12) @(posedge clk);
    #1;
    issue(4'b0010, 32'd2, 32'd3);
    drain();

    rdy_mode = 1;
    for (int i = 0; i < 250; i++) begin
      c = ($urandom_range(0, 7) == 0) ? 4'($urandom) : codes[$urandom_range(0, 8)];
      case ($urandom_range(0, 3))
        0: begin a = 32'h8000_0000; b = $urandom; end
        1: begin a = 32'h7FFF_FFFF; b = $urandom_range(0, 3); end
        default: begin a = $urandom; b = $urandom; end
      endcase
      if ($urandom_range(0, 7) == 0) b = a;
      issue(c, a, b);
      if ($urandom_range(0, 5) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
      #1;
    end
    rdy_mode = 0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
